// File: rtl/dump_sequencer_if.sv
// Command, capture-RAM and UART signal bundle seen by the dump sequencer.
// The sequencer takes the master side; command/RAM/UART models take the slave side.
interface dump_sequencer_if #(
  parameter int unsigned LOG2 = 9
);
  logic            strt_dump;
  logic [2:0]      channel;
  logic [LOG2-1:0] start_addr;
  logic [7:0]      rdataCH1;
  logic [7:0]      rdataCH2;
  logic [7:0]      rdataCH3;
  logic [7:0]      rdataCH4;
  logic [7:0]      rdataCH5;
  logic            tx_done;
  logic [LOG2-1:0] addr;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            busy;
  logic            dump_done;
  logic            dump_err;

  modport master (
    input  strt_dump, channel, start_addr,
    input  rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5,
    input  tx_done,
    output addr, tx_data, trmt, busy, dump_done, dump_err
  );

  modport slave (
    output strt_dump, channel, start_addr,
    output rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5,
    output tx_done,
    input  addr, tx_data, trmt, busy, dump_done, dump_err
  );
endinterface

// File: rtl/dump_sequencer.sv
// Walks one channel's circular capture RAM from the oldest sample and feeds
// each byte to the UART with a trmt/tx_done handshake, then pulses dump_done.
module dump_sequencer #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic             clk,
  input  logic             rst,
  dump_sequencer_if.master bus
);
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, RD, XMIT, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [LOG2-1:0] addr_q, addr_nxt;
  logic [LOG2-1:0] cnt_q, cnt_nxt;
  logic [2:0]      ch_q, ch_nxt;
  logic            err_q, err_nxt;
  logic [7:0]      tx_data_q, tx_data_nxt;
  logic            trmt_q, trmt_nxt;
  logic            done_q, done_nxt;
  logic            dump_err_q, dump_err_nxt;
  logic            busy_q;
  logic [7:0]      rdata_c;
  logic            ch_valid_c;

  // Read-data select for the latched channel
  always_comb begin
    rdata_c = 8'h00;
    case (ch_q)
      3'd1:    rdata_c = bus.rdataCH1;
      3'd2:    rdata_c = bus.rdataCH2;
      3'd3:    rdata_c = bus.rdataCH3;
      3'd4:    rdata_c = bus.rdataCH4;
      3'd5:    rdata_c = bus.rdataCH5;
      default: rdata_c = 8'h00;
    endcase
  end

  assign ch_valid_c = (bus.channel != 3'd0) && (bus.channel <= 3'd5);

  // Next-state and registered-output values
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    cnt_nxt      = cnt_q;
    ch_nxt       = ch_q;
    err_nxt      = err_q;
    tx_data_nxt  = tx_data_q;
    trmt_nxt     = 1'b0;
    done_nxt     = 1'b0;
    dump_err_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.strt_dump) begin
          ch_nxt  = bus.channel;
          cnt_nxt = '0;
          err_nxt = !ch_valid_c;
          if (ch_valid_c) begin
            // Out-of-range write pointer falls back to the start of the buffer
            addr_nxt  = (bus.start_addr > LAST) ? '0 : bus.start_addr;
            state_nxt = RD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RD:   state_nxt = XMIT;
      XMIT: begin
        tx_data_nxt = rdata_c;
        trmt_nxt    = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          if (cnt_q == LAST) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = cnt_q + LOG2'(1);
            addr_nxt  = (addr_q == LAST) ? '0 : addr_q + LOG2'(1);
            state_nxt = RD;
          end
        end
      end
      DONE: begin
        done_nxt     = 1'b1;
        dump_err_nxt = err_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      ch_q       <= 3'd0;
      err_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      trmt_q     <= 1'b0;
      done_q     <= 1'b0;
      dump_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_q     <= addr_nxt;
      cnt_q      <= cnt_nxt;
      ch_q       <= ch_nxt;
      err_q      <= err_nxt;
      tx_data_q  <= tx_data_nxt;
      trmt_q     <= trmt_nxt;
      done_q     <= done_nxt;
      dump_err_q <= dump_err_nxt;
      busy_q     <= (state != IDLE);
    end
  end

  assign bus.addr      = addr_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.trmt      = trmt_q;
  assign bus.busy      = busy_q;
  assign bus.dump_done = done_q;
  assign bus.dump_err  = dump_err_q;
endmodule

// File: tb/tb_dump_sequencer.sv
// Scoreboard bench for dump_sequencer: expected bytes come from a circular
// buffer model of the capture RAM and are matched on every trmt strobe.
module tb_dump_sequencer;
  localparam int unsigned ENTRIES = 384;
  localparam int unsigned LOG2    = 9;

  typedef struct {
    logic [7:0]      data;
    logic [LOG2-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dump_sequencer_if #(.LOG2(LOG2)) bus ();

  dump_sequencer #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [1:5][0:ENTRIES-1];
  exp_t       exp_q[$];
  logic       exp_done[$];
  int         checks    = 0;
  int         errors    = 0;
  int         n_trmt    = 0;
  int         rsp_delay = 10;
  int         rsp_hold  = 1;

  // Synchronous capture RAMs: data follows addr by one clock
  always @(posedge clk) begin
    if (bus.addr < LOG2'(ENTRIES)) begin
      bus.rdataCH1 <= mem[1][bus.addr];
      bus.rdataCH2 <= mem[2][bus.addr];
      bus.rdataCH3 <= mem[3][bus.addr];
      bus.rdataCH4 <= mem[4][bus.addr];
      bus.rdataCH5 <= mem[5][bus.addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic de;
    forever begin
      @(negedge clk);
      if (bus.trmt === 1'b1) begin
        n_trmt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_trmt: got trmt=1 expected no byte at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(bus.tx_data), 32'(e.data));
          chk("byte_addr", 32'(bus.addr), 32'(e.addr));
        end
      end
      if (bus.dump_done === 1'b1) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dump_done: got 1 expected 0 at %0t", $time);
        end else begin
          de = exp_done.pop_front();
          chk("dump_err", 32'(bus.dump_err), 32'(de));
        end
      end else if (bus.dump_err !== 1'b0) begin
        chk("dump_err_alone", 32'(bus.dump_err), 32'(0));
      end
    end
  endtask

  // UART model: tx_done rsp_delay cycles after trmt, held rsp_hold cycles
  task automatic responder();
    int wait_cnt = 0;
    int hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wait_cnt    = 0;
        hold_cnt    = 0;
        bus.tx_done = 1'b0;
      end else begin
        if (hold_cnt != 0) begin
          hold_cnt--;
          if (hold_cnt == 0) bus.tx_done = 1'b0;
        end
        if (bus.trmt === 1'b1) wait_cnt = rsp_delay;
        if (wait_cnt != 0) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            bus.tx_done = 1'b1;
            hold_cnt    = rsp_hold;
          end
        end
      end
    end
  endtask

  // Queue the model's expected bytes, then pulse strt_dump (returns just after edge N)
  task automatic issue(input logic [2:0] ch, input logic [LOG2-1:0] sa);
    int s;
    int ci;
    bit valid;
    exp_t e;
    ci    = int'(ch);
    valid = (ci >= 1) && (ci <= 5);
    s     = (int'(sa) >= int'(ENTRIES)) ? 0 : int'(sa);
    if (valid) begin
      for (int j = 0; j < int'(ENTRIES); j++) begin
        e.addr = LOG2'((s + j) % int'(ENTRIES));
        e.data = mem[ci][(s + j) % int'(ENTRIES)];
        exp_q.push_back(e);
      end
    end
    exp_done.push_back(!valid);
    @(posedge clk); #1;
    bus.strt_dump  = 1'b1;
    bus.channel    = ch;
    bus.start_addr = sa;
    @(posedge clk); #1;
    bus.strt_dump  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && exp_done.size() == 0 && bus.busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    chk("dump_complete", 32'(ok), 32'(1));
  endtask

  task automatic wait_bytes(input int target);
    bit ok = 0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (n_trmt >= target) begin
        ok = 1;
        break;
      end
    end
    chk("byte_progress", 32'(ok), 32'(1));
  endtask

  initial begin
    int base;
    logic [LOG2-1:0] old_addr;
    logic [2:0] bad_ch [3];
    rst            = 1'b1;
    bus.strt_dump  = 1'b0;
    bus.channel    = 3'd0;
    bus.start_addr = '0;
    for (int c = 1; c <= 5; c++)
      for (int i = 0; i < int'(ENTRIES); i++)
        mem[c][i] = (c == 1) ? 8'(i) : 8'($urandom);
    fork
      monitor();
      responder();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_addr", 32'(bus.addr), 32'(0));
    chk("rst_tx_data", 32'(bus.tx_data), 32'(0));
    chk("rst_trmt", 32'(bus.trmt), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_dump_done", 32'(bus.dump_done), 32'(0));
    chk("rst_dump_err", 32'(bus.dump_err), 32'(0));

    // CH1 from address 0 with a 10-cycle UART, including start-up latency
    rsp_delay = 10;
    base = n_trmt;
    issue(3'd1, 9'd0);
    chk("start_addr_load", 32'(bus.addr), 32'(0));
    @(posedge clk); #1;
    chk("busy_rise", 32'(bus.busy), 32'(1));
    chk("trmt_not_yet", 32'(bus.trmt), 32'(0));
    @(posedge clk); #1;
    chk("first_trmt", 32'(bus.trmt), 32'(1));
    chk("first_byte", 32'(bus.tx_data), 32'(8'h00));
    wait_idle();
    chk("ch1_count", 32'(n_trmt - base), 32'(ENTRIES));

    // CH3 wrap-around from 380
    rsp_delay = int'($urandom_range(1, 4));
    base = n_trmt;
    issue(3'd3, 9'd380);
    chk("wrap_start_addr", 32'(bus.addr), 32'(380));
    wait_idle();
    chk("ch3_count", 32'(n_trmt - base), 32'(ENTRIES));

    // Invalid channels: immediate done+err, no bytes, addr untouched
    bad_ch[0] = 3'd6;
    bad_ch[1] = 3'd0;
    bad_ch[2] = 3'd7;
    for (int k = 0; k < 3; k++) begin
      base     = n_trmt;
      old_addr = bus.addr;
      issue(bad_ch[k], LOG2'($urandom_range(0, 383)));
      @(posedge clk); #1;
      chk("bad_done", 32'(bus.dump_done), 32'(1));
      chk("bad_err", 32'(bus.dump_err), 32'(1));
      chk("bad_addr", 32'(bus.addr), 32'(old_addr));
      chk("bad_busy_hold", 32'(bus.busy), 32'(1));
      @(posedge clk); #1;
      chk("bad_busy_drop", 32'(bus.busy), 32'(0));
      chk("bad_done_drop", 32'(bus.dump_done), 32'(0));
      wait_idle();
      chk("bad_count", 32'(n_trmt - base), 32'(0));
    end

    // CH2 with a re-issued request and channel change mid-dump
    rsp_delay = int'($urandom_range(1, 4));
    base = n_trmt;
    issue(3'd2, LOG2'($urandom_range(0, 383)));
    wait_bytes(base + 50);
    bus.strt_dump  = 1'b1;
    bus.channel    = 3'd5;
    bus.start_addr = 9'd7;
    @(posedge clk); #1;
    bus.strt_dump  = 1'b0;
    wait_idle();
    chk("ch2_count", 32'(n_trmt - base), 32'(ENTRIES));
    repeat (20) @(posedge clk);
    #1 chk("ch2_no_restart", 32'(bus.busy), 32'(0));

    // Reset abort while waiting on byte 100
    rsp_delay = 10;
    base = n_trmt;
    issue(3'd4, LOG2'($urandom_range(0, 383)));
    wait_bytes(base + 101);
    @(posedge clk); #1;
    exp_q.delete();
    exp_done.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_addr", 32'(bus.addr), 32'(0));
    chk("abort_trmt", 32'(bus.trmt), 32'(0));
    chk("abort_tx_data", 32'(bus.tx_data), 32'(0));
    chk("abort_done", 32'(bus.dump_done), 32'(0));
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("abort_idle", 32'(bus.busy), 32'(0));
    rsp_delay = int'($urandom_range(1, 4));
    base = n_trmt;
    issue(3'd5, LOG2'($urandom_range(0, 383)));
    wait_idle();
    chk("post_abort_count", 32'(n_trmt - base), 32'(ENTRIES));

    // Out-of-range start with tx_done stretched into RD/XMIT
    rsp_delay = int'($urandom_range(1, 5));
    rsp_hold  = 3;
    base = n_trmt;
    issue(3'd4, 9'd500);
    chk("oor_start_addr", 32'(bus.addr), 32'(0));
    wait_idle();
    chk("oor_count", 32'(n_trmt - base), 32'(ENTRIES));
    rsp_hold = 1;

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
